mmio_uart_ctrl: RTL and testbench
=================================

MMIO_UART_CTRL -- requirements
Module: mmio_uart_ctrl

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 8, meaning TX FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter RX_DEPTH, default 8, meaning RX FIFO entries (power of two, 2..256).
REQ-003 SHALL have parameter LED_WIDTH, default 16, meaning LED register width (1..32).
REQ-004 SHALL have parameters UART_BASE (default 32'h1000_0000) and LED_BASE (default 32'h2000_0000), meaning the decoded addresses.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports addr (input, 32) and wdata (input, 32), the CPU MEM-stage address and store data.
REQ-008 SHALL have ports we and re, input, 1 each, the CPU store and load strobes.
REQ-009 SHALL have ports rdata (output, 32, load data) and hit (output, 1, addr matches a mapped register).
REQ-010 SHALL have port led_out, output, LED_WIDTH, the LED register.
REQ-011 SHALL have ports uart_tx_data (output, 8), uart_tx_we (output, 1) and uart_tx_busy (input, 1) toward the transmitter.
REQ-012 SHALL have ports uart_rx_data (input, 8), uart_rx_valid (input, 1) and uart_rx_re (output, 1) toward the receiver.
REQ-013 SHALL have port irq, output, 1, the level interrupt request.

Function
REQ-014 SHALL decode DATA=UART_BASE+0, STATUS=UART_BASE+4, CTRL=UART_BASE+8 and LED=LED_BASE by exact 32-bit match; hit=1 only for these four.
REQ-015 SHALL drive rdata combinationally from addr with zero-cycle latency: DATA gives {24'b0, RX head} (0 if RX empty); STATUS gives the word in REQ-016; CTRL gives {30'b0, tx_ie, rx_ie}; LED gives zero-extended led_out; unmapped addresses give 0.
REQ-016 SHALL format STATUS as bit0 rx_not_empty, bit1 tx_full, bit2 tx_empty, bit3 rx_ovf (sticky), bit4 tx_ovf (sticky), bits[15:8] rx_count, bits[23:16] tx_count, other bits 0.
REQ-017 SHALL pop the RX FIFO on a rising edge only when re=1, addr=DATA and RX is non-empty; a read of an empty FIFO changes no state.
REQ-018 SHALL push wdata[7:0] into the TX FIFO when we=1 and addr=DATA; if TX is full and no drain occurs in the same cycle, it SHALL drop the byte and set tx_ovf.
REQ-019 SHALL clear rx_ovf and tx_ovf on a write to STATUS wherever wdata bit3 or bit4 is 1; a same-cycle overflow event SHALL win over the clear.
REQ-020 SHALL load rx_ie=wdata[0] and tx_ie=wdata[1] on a write to CTRL, and led_out=wdata[LED_WIDTH-1:0] on a write to LED.
REQ-021 SHALL implement a TX drain FSM with states IDLE, SEND and GAP: in IDLE, when TX is non-empty and uart_tx_busy=0, it SHALL register uart_tx_data=head, pulse uart_tx_we for exactly one cycle, pop, and enter SEND; SEND SHALL go to GAP; GAP SHALL return to IDLE once uart_tx_busy=0. Two uart_tx_we pulses are therefore separated by at least 2 idle cycles.
REQ-022 SHALL capture uart_rx_data when uart_rx_valid=1 and uart_rx_re was 0 in the previous cycle, and SHALL register a one-cycle uart_rx_re acknowledge; if RX is full and no pop occurs that cycle, it SHALL discard the byte, set rx_ovf, and still acknowledge.
REQ-023 SHALL allow push and pop on the same FIFO in the same cycle, including at full or empty, leaving the count unchanged; a pop from empty SHALL be ignored.
REQ-024 SHALL use circular read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, with a count of log2(DEPTH)+1 bits; full means count=DEPTH.
REQ-025 SHALL drive irq = (rx_ie & rx_not_empty) | (tx_ie & tx_empty) from registered state only.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, empty both FIFOs and clear the pointers, counts, rx_ovf, tx_ovf, rx_ie, tx_ie, led_out, uart_tx_we, uart_tx_data and uart_rx_re, and SHALL set the FSM to IDLE; this includes reset in the middle of a transfer.
REQ-027 SHALL give rst priority over every simultaneous we, re and uart_rx_valid event in the same cycle.

Verification
REQ-028 SHALL pass this scenario: after reset, read STATUS -> rdata=32'h0000_0004, irq=0, led_out=0.
REQ-029 SHALL pass this scenario: write 0x41, 0x42 to DATA with uart_tx_busy=0 -> uart_tx_data 0x41 then 0x42, each with a one-cycle uart_tx_we, the pulses at least 3 cycles apart, tx_empty=1 afterwards.
REQ-030 SHALL pass this scenario: hold uart_tx_busy=1 and write 9 bytes with TX_DEPTH=8 -> tx_count=8, tx_ovf=1, no uart_tx_we; then write STATUS=0x10 -> tx_ovf=0.
REQ-031 SHALL pass this scenario: present RX bytes 0x10..0x18 (9 bytes) with RX_DEPTH=8 -> 9 uart_rx_re pulses, rx_count=8, rx_ovf=1; DATA reads return 0x10..0x17 in order, and a 9th read returns 0 with no state change.
REQ-032 SHALL pass this scenario: RX full, and a DATA read coincides with a new uart_rx_valid -> the byte is accepted, rx_count stays 8, rx_ovf is unchanged.
REQ-033 SHALL pass this scenario: CTRL=0x1 with one RX byte -> irq=1; pop it -> irq=0; assert rst during a SEND state -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/mmio_uart_ctrl.sv
// rtl/mmio_uart_ctrl.sv - memory-mapped UART/LED register block with TX/RX FIFOs and TX drain FSM
module mmio_uart_ctrl #(
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8,
  parameter int          LED_WIDTH = 16,
  parameter logic [31:0] UART_BASE = 32'h1000_0000,
  parameter logic [31:0] LED_BASE  = 32'h2000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic                 we,
  input  logic                 re,
  output logic [31:0]          rdata,
  output logic                 hit,
  output logic [LED_WIDTH-1:0] led_out,
  output logic [7:0]           uart_tx_data,
  output logic                 uart_tx_we,
  input  logic                 uart_tx_busy,
  input  logic [7:0]           uart_rx_data,
  input  logic                 uart_rx_valid,
  output logic                 uart_rx_re,
  output logic                 irq
);

  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam logic [TXA:0] TX_FULL_CNT = (TXA+1)'(TX_DEPTH);
  localparam logic [RXA:0] RX_FULL_CNT = (RXA+1)'(RX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} tx_state_t;

  logic [7:0]           r_tx_mem [TX_DEPTH];
  logic [7:0]           r_rx_mem [RX_DEPTH];
  logic [TXA-1:0]       r_tx_wp, r_tx_rp;
  logic [RXA-1:0]       r_rx_wp, r_rx_rp;
  logic [TXA:0]         r_tx_cnt;
  logic [RXA:0]         r_rx_cnt;
  logic                 r_rx_ovf, r_tx_ovf, r_rx_ie, r_tx_ie;
  logic [LED_WIDTH-1:0] r_led;
  logic                 r_tx_we, r_rx_re;
  logic [7:0]           r_tx_data;
  tx_state_t            r_state, w_next;

  logic w_sel_data, w_sel_status, w_sel_ctrl, w_sel_led;
  logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic w_tx_wr, w_tx_push, w_tx_pop, w_tx_ovf_set;
  logic w_rx_in, w_rx_push, w_rx_pop, w_rx_ovf_set;
  logic [31:0] w_status, w_tx_cnt32, w_rx_cnt32;
  logic w_unused;

  assign w_sel_data   = (addr == UART_BASE);
  assign w_sel_status = (addr == UART_BASE + 32'd4);
  assign w_sel_ctrl   = (addr == UART_BASE + 32'd8);
  assign w_sel_led    = (addr == LED_BASE);
  assign hit          = w_sel_data | w_sel_status | w_sel_ctrl | w_sel_led;

  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == TX_FULL_CNT);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == RX_FULL_CNT);

  // A full FIFO still accepts a byte when a pop frees a slot on the same edge.
  assign w_tx_wr      = we & w_sel_data;
  assign w_tx_push    = w_tx_wr & (~w_tx_full | w_tx_pop);
  assign w_tx_ovf_set = w_tx_wr & w_tx_full & ~w_tx_pop;

  // The ack register masks uart_rx_valid for one cycle so each byte is taken once.
  assign w_rx_in      = uart_rx_valid & ~r_rx_re;
  assign w_rx_pop     = re & w_sel_data & ~w_rx_empty;
  assign w_rx_push    = w_rx_in & (~w_rx_full | w_rx_pop);
  assign w_rx_ovf_set = w_rx_in & w_rx_full & ~w_rx_pop;

  assign w_tx_cnt32 = 32'(r_tx_cnt);
  assign w_rx_cnt32 = 32'(r_rx_cnt);
  assign w_status   = {8'b0, w_tx_cnt32[7:0], w_rx_cnt32[7:0], 3'b0,
                       r_tx_ovf, r_rx_ovf, w_tx_empty, w_tx_full, ~w_rx_empty};
  assign w_unused   = ^{wdata, w_tx_cnt32, w_rx_cnt32};

  assign led_out      = r_led;
  assign uart_tx_we   = r_tx_we;
  assign uart_tx_data = r_tx_data;
  assign uart_rx_re   = r_rx_re;
  assign irq          = (r_rx_ie & ~w_rx_empty) | (r_tx_ie & w_tx_empty);

  // Load-data mux, zero-latency from addr.
  always_comb begin
    rdata = '0;
    if (w_sel_data && !w_rx_empty) rdata = {24'b0, r_rx_mem[r_rx_rp]};
    else if (w_sel_status)         rdata = w_status;
    else if (w_sel_ctrl)           rdata = {30'b0, r_tx_ie, r_rx_ie};
    else if (w_sel_led)            rdata = 32'(r_led);
  end

  // TX drain next-state: pop only from IDLE when the transmitter is free.
  always_comb begin
    w_next   = r_state;
    w_tx_pop = 1'b0;
    case (r_state)
      S_IDLE: if (!w_tx_empty && !uart_tx_busy) begin
        w_tx_pop = 1'b1;
        w_next   = S_SEND;
      end
      S_SEND:  w_next = S_GAP;
      S_GAP:   if (!uart_tx_busy) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FIFO storage; occupancy is tracked by the counters, so contents need no reset.
  always_ff @(posedge clk) begin
    if (!rst && w_tx_push) r_tx_mem[r_tx_wp] <= wdata[7:0];
    if (!rst && w_rx_push) r_rx_mem[r_rx_wp] <= uart_rx_data;
  end

  // Control state, pointers, counts, flags and registered UART strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tx_wp   <= '0;
      r_tx_rp   <= '0;
      r_tx_cnt  <= '0;
      r_rx_wp   <= '0;
      r_rx_rp   <= '0;
      r_rx_cnt  <= '0;
      r_rx_ovf  <= 1'b0;
      r_tx_ovf  <= 1'b0;
      r_rx_ie   <= 1'b0;
      r_tx_ie   <= 1'b0;
      r_led     <= '0;
      r_tx_we   <= 1'b0;
      r_tx_data <= '0;
      r_rx_re   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tx_we <= w_tx_pop;
      r_rx_re <= w_rx_in;
      if (w_tx_pop) r_tx_data <= r_tx_mem[r_tx_rp];

      if (w_tx_push) r_tx_wp <= r_tx_wp + TXA'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + TXA'(1);
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + (TXA+1)'(1);
      else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - (TXA+1)'(1);

      if (w_rx_push) r_rx_wp <= r_rx_wp + RXA'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + RXA'(1);
      if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + (RXA+1)'(1);
      else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - (RXA+1)'(1);

      // A fresh overflow beats a same-cycle clear.
      if (w_rx_ovf_set)                        r_rx_ovf <= 1'b1;
      else if (we && w_sel_status && wdata[3]) r_rx_ovf <= 1'b0;
      if (w_tx_ovf_set)                        r_tx_ovf <= 1'b1;
      else if (we && w_sel_status && wdata[4]) r_tx_ovf <= 1'b0;

      if (we && w_sel_ctrl) begin
        r_rx_ie <= wdata[0];
        r_tx_ie <= wdata[1];
      end
      if (we && w_sel_led) r_led <= wdata[LED_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// tb/tb_mmio_uart_ctrl.sv - directed scoreboard bench for mmio_uart_ctrl
module tb_mmio_uart_ctrl;

  localparam logic [31:0] DATA_A   = 32'h1000_0000;
  localparam logic [31:0] STATUS_A = 32'h1000_0004;
  localparam logic [31:0] CTRL_A   = 32'h1000_0008;
  localparam logic [31:0] LED_A    = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst, we, re, hit;
  logic [31:0] addr, wdata, rdata;
  logic [15:0] led_out;
  logic [7:0]  uart_tx_data, uart_rx_data;
  logic        uart_tx_we, uart_tx_busy, uart_rx_valid, uart_rx_re, irq;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int rx_re_cnt = 0;
  int p_idx    = 0;
  logic [7:0] p_data [$];
  int         p_cyc  [$];
  logic [7:0] tx_exp [$];
  logic [7:0] rx_exp [$];

  mmio_uart_ctrl dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .hit(hit), .led_out(led_out),
    .uart_tx_data(uart_tx_data), .uart_tx_we(uart_tx_we), .uart_tx_busy(uart_tx_busy),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_re(uart_rx_re),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Record every transmit strobe and receive acknowledge mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (uart_tx_we) begin
      p_data.push_back(uart_tx_data);
      p_cyc.push_back(cyc);
    end
    if (uart_rx_re) rx_re_cnt = rx_re_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic look(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic rd_pop(input string tag, input logic [31:0] exp);
    addr = DATA_A; re = 1'b1;
    #1;
    chk(tag, rdata, exp);
    tick();
    re = 1'b0; addr = '0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    uart_rx_data = b; uart_rx_valid = 1'b1;
    tick();
    chk("rx_ack", uart_rx_re, 1);
    uart_rx_valid = 1'b0;
    tick();
  endtask

  task automatic drain_check(input string tag, input int n);
    int t = 0;
    while (p_data.size() < p_idx + n && t < 300) begin
      tick();
      t++;
    end
    chk({tag, "_pulses"}, (p_data.size() >= p_idx + n), 1);
    for (int k = 0; k < n && p_idx < p_data.size() && tx_exp.size() > 0; k++) begin
      chk({tag, "_byte"}, p_data[p_idx], tx_exp.pop_front());
      if (k > 0) chk({tag, "_gap"}, (p_cyc[p_idx] - p_cyc[p_idx-1] >= 3), 1);
      p_idx++;
    end
  endtask

  initial begin
    int t;
    rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
    uart_tx_busy = 1'b0; uart_rx_data = '0; uart_rx_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state and decode boundaries
    look("rst_status", STATUS_A, 32'h0000_0004);
    chk("rst_hit", hit, 1);
    chk("rst_irq", irq, 0);
    chk("rst_led", led_out, 0);
    chk("rst_tx_we", uart_tx_we, 0);
    look("unmapped_c", DATA_A + 32'd12, 0);
    chk("unmapped_c_hit", hit, 0);
    look("unmapped_1", DATA_A + 32'd1, 0);
    chk("unmapped_1_hit", hit, 0);

    // LED register
    wr(LED_A, 32'hABCD_1234);
    chk("led_out", led_out, 16'h1234);
    look("led_read", LED_A, 32'h0000_1234);

    // Two-byte transmit with the transmitter idle
    tx_exp.push_back(8'h41); tx_exp.push_back(8'h42);
    wr(DATA_A, 32'h41);
    wr(DATA_A, 32'h42);
    drain_check("tx2", 2);
    repeat (4) tick();
    look("tx2_empty", STATUS_A, 32'h0000_0004);

    // TX overflow while the transmitter is busy
    uart_tx_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr(DATA_A, 32'h50 + i);
      if (i < 8) tx_exp.push_back(8'(8'h50 + i));
    end
    look("txovf_status", STATUS_A, 32'h0008_0012);
    chk("txovf_no_we", p_data.size(), p_idx);
    wr(STATUS_A, 32'h10);
    look("txovf_clear", STATUS_A, 32'h0008_0002);
    uart_tx_busy = 1'b0;
    drain_check("txdrain", 8);
    repeat (4) tick();
    look("txdrain_empty", STATUS_A, 32'h0000_0004);

    // RX fill with overflow on the ninth byte
    for (int i = 0; i < 9; i++) begin
      rx_byte(8'(8'h10 + i));
      if (i < 8) rx_exp.push_back(8'(8'h10 + i));
    end
    chk("rx_ack_count", rx_re_cnt, 9);
    look("rxovf_status", STATUS_A, 32'h0000_080D);

    // Overflow beats a same-cycle clear
    uart_rx_data = 8'h19; uart_rx_valid = 1'b1;
    addr = STATUS_A; wdata = 32'h08; we = 1'b1;
    tick();
    chk("ovf_win_ack", uart_rx_re, 1);
    uart_rx_valid = 1'b0; we = 1'b0;
    tick();
    look("ovf_win_status", STATUS_A, 32'h0000_080D);
    wr(STATUS_A, 32'h08);
    look("rxovf_clear", STATUS_A, 32'h0000_0805);

    // Pop and capture in the same cycle at full
    addr = DATA_A; re = 1'b1; uart_rx_data = 8'h1A; uart_rx_valid = 1'b1;
    #1;
    chk("popcap_data", rdata, {24'b0, rx_exp.pop_front()});
    tick();
    chk("popcap_ack", uart_rx_re, 1);
    re = 1'b0; uart_rx_valid = 1'b0;
    rx_exp.push_back(8'h1A);
    tick();
    look("popcap_status", STATUS_A, 32'h0000_0805);

    // Drain RX in order, then read empty
    while (rx_exp.size() > 0) rd_pop("rx_data", {24'b0, rx_exp.pop_front()});
    rd_pop("rx_empty_read", 0);
    look("rx_empty_status", STATUS_A, 32'h0000_0004);

    // Interrupts
    wr(CTRL_A, 32'h1);
    look("ctrl_read", CTRL_A, 32'h1);
    chk("irq_none", irq, 0);
    rx_byte(8'h33);
    chk("irq_rx", irq, 1);
    rd_pop("irq_pop", 32'h33);
    chk("irq_rx_clear", irq, 0);
    wr(CTRL_A, 32'h2);
    chk("irq_tx", irq, 1);
    wr(CTRL_A, 32'h3);

    // Reset during SEND, with colliding bus and receive events
    tx_exp.push_back(8'h77);
    wr(DATA_A, 32'h77);
    t = 0;
    while (!uart_tx_we && t < 10) begin
      tick();
      t++;
    end
    chk("send_seen", uart_tx_we, 1);
    rst = 1'b1; addr = DATA_A; wdata = 32'h99; we = 1'b1;
    uart_rx_data = 8'h55; uart_rx_valid = 1'b1;
    tick();
    we = 1'b0; uart_rx_valid = 1'b0; rst = 1'b0;
    chk("midrst_led", led_out, 0);
    chk("midrst_tx_we", uart_tx_we, 0);
    chk("midrst_tx_data", uart_tx_data, 0);
    chk("midrst_rx_re", uart_rx_re, 0);
    chk("midrst_irq", irq, 0);
    look("midrst_data", DATA_A, 0);
    look("midrst_status", STATUS_A, 32'h0000_0004);
    drain_check("midrst", 1);
    repeat (10) tick();
    chk("midrst_no_more_tx", p_data.size(), p_idx);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
